// File: rtl/multi_door_blinker_if.sv
// Bundle of door-sensor inputs and lamp/status outputs for the multi-channel door blinker.
// The blinker connects through the slave modport; the parking controller uses master.
interface multi_door_blinker_if #(
    parameter int unsigned N_CH = 4
) ();
    logic [N_CH-1:0] door_open;
    logic            hold_mode;
    logic [N_CH-1:0] light;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] done;
    logic            any_busy;

    modport master (
        output door_open,
        output hold_mode,
        input  light,
        input  busy,
        input  done,
        input  any_busy
    );

    modport slave (
        input  door_open,
        input  hold_mode,
        output light,
        output busy,
        output done,
        output any_busy
    );
endinterface

// File: rtl/multi_door_blinker.sv
// Multi-channel open-door lamp blinker: each channel runs a PHASES x DIV-cycle blink sequence
// on every door opening, with optional hold-while-open and a one-cycle done pulse.
module multi_door_blinker #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DIV    = 25000000,
    parameter int unsigned PHASES = 10
) (
    input logic                CLK,
    input logic                RST,
    multi_door_blinker_if.slave bus
);

    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PhW  = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);
    localparam logic [PhW-1:0]  PhMax  = PhW'(PHASES - 1);

    typedef enum logic {StIdle, StBlink} state_e;

    logic [N_CH-1:0] sync1_q, sync2_q, sync3_q;
    logic [N_CH-1:0] rise;

    state_e          state_q [N_CH];
    state_e          state_d [N_CH];
    logic [DivW-1:0] div_q   [N_CH];
    logic [DivW-1:0] div_d   [N_CH];
    logic [PhW-1:0]  pcnt_q  [N_CH];
    logic [PhW-1:0]  pcnt_d  [N_CH];
    logic [N_CH-1:0] light_q, light_d;
    logic [N_CH-1:0] done_q, done_d;
    logic [N_CH-1:0] busy;

    // sync3 is the previous sync2 value, used only for rising-edge detection.
    assign rise = sync2_q & ~sync3_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            light_q <= '0;
            done_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= StIdle;
                div_q[i]   <= '0;
                pcnt_q[i]  <= '0;
            end
        end else begin
            sync1_q <= bus.door_open;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            light_q <= light_d;
            done_q  <= done_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                div_q[i]   <= div_d[i];
                pcnt_q[i]  <= pcnt_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pcnt_d  = pcnt_q;
        light_d = light_q;
        done_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rise[i]) begin
                // A new opening always restarts, even on the final tick.
                state_d[i] = StBlink;
                light_d[i] = 1'b1;
                div_d[i]   = '0;
                pcnt_d[i]  = '0;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        light_d[i] = 1'b0;
                        div_d[i]   = '0;
                        pcnt_d[i]  = '0;
                    end
                    StBlink: begin
                        if (div_q[i] != DivMax) begin
                            div_d[i] = div_q[i] + DivW'(1);
                        end else begin
                            div_d[i] = '0;
                            if (pcnt_q[i] != PhMax) begin
                                light_d[i] = ~light_q[i];
                                pcnt_d[i]  = pcnt_q[i] + PhW'(1);
                            end else if (bus.hold_mode && sync2_q[i]) begin
                                light_d[i] = 1'b1;
                                pcnt_d[i]  = '0;
                            end else begin
                                light_d[i] = 1'b0;
                                pcnt_d[i]  = '0;
                                state_d[i] = StIdle;
                                done_d[i]  = 1'b1;
                            end
                        end
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < N_CH; i++) begin
            busy[i] = (state_q[i] == StBlink);
        end
    end

    assign bus.light    = light_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy;
    assign bus.any_busy = |busy;

endmodule

// File: tb/tb_multi_door_blinker.sv
// Bench for multi_door_blinker: directed scenarios plus random door traffic, checked every
// cycle against an elapsed-time model of the blink sequence.
module tb_multi_door_blinker;

    localparam int NCH = 2;
    localparam int DIV = 4;
    localparam int PH  = 4;
    localparam int SEQ = DIV * PH;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    multi_door_blinker_if #(.N_CH(NCH)) bus_a ();
    multi_door_blinker_if #(.N_CH(1))   bus_b ();

    multi_door_blinker #(.N_CH(NCH), .DIV(DIV), .PHASES(PH)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    multi_door_blinker #(.N_CH(1), .DIV(2), .PHASES(2)) u_dut_rst (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    int checks = 0;
    int errors = 0;
    int busy_cnt0 = 0;
    int done_cnt0 = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a channel is busy from the edge its rise is seen; light depends only on
    // elapsed cycles since sequence start.
    logic [NCH-1:0] m_busy, m_light, m_done;
    int             m_start [NCH];
    logic [NCH-1:0] hist [$];
    int             k = 0;

    task automatic model_reset();
        m_busy  = '0;
        m_light = '0;
        m_done  = '0;
        hist    = {};
        for (int i = 0; i < 3; i++) hist.push_back('0);
    endtask

    task automatic model_edge();
        logic [NCH-1:0] d2, d3;
        d2 = hist[$-1];
        d3 = hist[$-2];
        k++;
        for (int i = 0; i < NCH; i++) begin
            m_done[i] = 1'b0;
            if (d2[i] && !d3[i]) begin
                m_busy[i]  = 1'b1;
                m_start[i] = k;
            end else if (m_busy[i] && (k - m_start[i] == SEQ)) begin
                if (bus_a.hold_mode && d2[i]) begin
                    m_start[i] = k;
                end else begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end
            end
            m_light[i] = m_busy[i] && ((((k - m_start[i]) / DIV) % 2) == 0);
        end
        hist.push_back(bus_a.door_open);
        void'(hist.pop_front());
    endtask

    task automatic compare_main();
        check_val("light",    32'(bus_a.light),    32'(m_light));
        check_val("busy",     32'(bus_a.busy),     32'(m_busy));
        check_val("done",     32'(bus_a.done),     32'(m_done));
        check_val("any_busy", 32'(bus_a.any_busy), 32'(|m_busy));
    endtask

    task automatic step();
        @(posedge CLK);
        if (RST) model_reset();
        else model_edge();
        @(negedge CLK);
        compare_main();
        if (bus_a.busy[0]) busy_cnt0++;
        if (bus_a.done[0]) done_cnt0++;
    endtask

    initial begin
        bus_a.door_open = '0;
        bus_a.hold_mode = 1'b0;
        bus_b.door_open = '0;
        bus_b.hold_mode = 1'b0;
        model_reset();
        step();
        step();
        RST = 1'b0;

        // One-shot on channel 0
        busy_cnt0 = 0;
        done_cnt0 = 0;
        bus_a.door_open = 2'b01;
        step();
        bus_a.door_open = 2'b00;
        step();
        check_val("s1_light_e2", 32'(bus_a.light[0]), 32'd0);
        step();
        check_val("s1_light_e3", 32'(bus_a.light[0]), 32'd1);
        repeat (22) step();
        check_val("s1_busy_len", 32'(busy_cnt0), 32'd16);
        check_val("s1_done_cnt", 32'(done_cnt0), 32'd1);
        check_val("s1_ch1_idle", 32'(bus_a.light[1]), 32'd0);

        // Retrigger during phase 2
        done_cnt0 = 0;
        busy_cnt0 = 0;
        bus_a.door_open = 2'b01;
        step();
        bus_a.door_open = 2'b00;
        repeat (10) step();
        bus_a.door_open = 2'b01;
        step();
        bus_a.door_open = 2'b00;
        repeat (30) step();
        check_val("s2_done_cnt", 32'(done_cnt0), 32'd1);
        check_val("s2_busy_len", 32'(busy_cnt0), 32'd27);

        // Hold mode
        done_cnt0 = 0;
        bus_a.hold_mode = 1'b1;
        bus_a.door_open = 2'b01;
        repeat (40) step();
        check_val("s3_no_done", 32'(done_cnt0), 32'd0);
        bus_a.door_open = 2'b00;
        repeat (20) step();
        bus_a.hold_mode = 1'b0;
        check_val("s3_done_cnt", 32'(done_cnt0), 32'd1);

        // Staggered channels
        bus_a.door_open = 2'b01;
        step();
        bus_a.door_open = 2'b00;
        repeat (2) step();
        bus_a.door_open = 2'b10;
        step();
        bus_a.door_open = 2'b00;
        repeat (24) step();

        // Rise coinciding with the final tick
        done_cnt0 = 0;
        bus_a.door_open = 2'b01;
        step();
        bus_a.door_open = 2'b00;
        repeat (2) step();
        repeat (13) step();
        bus_a.door_open = 2'b01;
        step();
        bus_a.door_open = 2'b00;
        step();
        step();
        check_val("s6_light", 32'(bus_a.light[0]), 32'd1);
        check_val("s6_busy",  32'(bus_a.busy[0]),  32'd1);
        check_val("s6_done",  32'(bus_a.done[0]),  32'd0);
        repeat (20) step();
        check_val("s6_done_cnt", 32'(done_cnt0), 32'd1);

        // Random traffic
        repeat (400) begin
            if ($urandom_range(0, 5) == 0) bus_a.door_open = NCH'($urandom);
            if ($urandom_range(0, 9) == 0) bus_a.hold_mode = 1'($urandom);
            step();
        end

        // Reset mid-blink on the small-config instance
        bus_b.door_open = 1'b1;
        repeat (5) step();
        check_val("s5_ph1_light", 32'(bus_b.light), 32'd0);
        check_val("s5_ph1_busy",  32'(bus_b.busy),  32'd1);
        RST = 1'b1;
        #1;
        check_val("s5_rst_light", 32'(bus_b.light), 32'd0);
        check_val("s5_rst_busy",  32'(bus_b.busy),  32'd0);
        check_val("s5_rst_done",  32'(bus_b.done),  32'd0);
        model_reset();
        compare_main();
        step();
        RST = 1'b0;
        step();
        check_val("s5_rel_e1", 32'(bus_b.light), 32'd0);
        step();
        check_val("s5_rel_e2", 32'(bus_b.light), 32'd0);
        step();
        check_val("s5_rel_e3", 32'(bus_b.light), 32'd1);
        check_val("s5_rel_busy", 32'(bus_b.any_busy), 32'd1);
        bus_b.door_open = 1'b0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_door_blinker.md
Name: multi_door_blinker

Overview:
- Parametrised, multi-channel successor to the single-door open-door blinker in the parking controller.
- Each channel watches one door_open line. On every opening it runs a blink sequence of PHASES half-periods, each exactly DIV clock cycles long. A per-channel prescaler replaces the shared external clock divider.
- Adds a hold mode (keep blinking while the door stays open), busy/done status, and synchronised, edge-detected inputs.
- Drives the per-gate warning lamps and reports activity to the parking FSM.

Parameters:
- N_CH, 4: number of independent door channels (>=1).
- DIV, 25000000: CLK cycles per half-period (>=1); 1 means toggle every cycle.
- PHASES, 10: half-periods per sequence (even, >=2); the light is high in phases 0,2,4,...

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- door_open  in  N_CH  per-channel door sensor, asynchronous level.
- hold_mode  in  1  1 = keep blinking while the door is open; 0 = one-shot sequence. Global to all channels.
- light  out  N_CH  per-channel lamp drive.
- busy  out  N_CH  channel is in BLINK.
- done  out  N_CH  one-cycle pulse when a sequence ends normally.
- any_busy  out  1  OR of busy.

Behaviour:
- Reset (async, active-high, immediate without a clock edge):
  - light, busy, done, any_busy = 0.
  - All sync flops, edge-detect registers, prescalers and phase counters = 0.
  - All channels in IDLE.
- Input path, per channel: 2-flop synchroniser, then a registered copy for edge detection.
  - rise = sync2 & ~sync3.
  - door_open going high before CLK edge 1 gives light = 1 at edge 3.
- Widths:
  - Prescaler: max(1, clog2(DIV)) bits.
  - Phase counter: max(1, clog2(PHASES)) bits.
  - Both wrap only as defined below, never by natural overflow.
- Per-channel FSM, states IDLE and BLINK:
  - rise, in any state → light = 1, pcnt = 0, div = 0, state BLINK. Rise has top priority.
  - BLINK with no rise, div != DIV-1 → div++.
  - BLINK, div == DIV-1 (tick) → div = 0, then:
    - pcnt != PHASES-1 → light toggles, pcnt++.
    - pcnt == PHASES-1, hold_mode = 1 and sync2 = 1 → light = 1, pcnt = 0. Seamless restart; no done pulse.
    - Otherwise → light = 0, pcnt = 0, state IDLE, done = 1 for exactly one cycle.
  - IDLE with no rise → light = 0, counters hold at 0.
- Timing and status:
  - Each phase lasts exactly DIV cycles.
  - A one-shot sequence keeps light asserted-or-blinking for PHASES*DIV cycles after light first goes high.
  - busy = (state == BLINK), registered alongside the state.
  - any_busy is combinational OR of busy.
  - done is registered: high in the first cycle light reads 0 after the final tick.
- Boundary conditions:
  - Rise on the same edge as the final tick: restart wins; no done pulse.
  - Door closing mid-sequence: no effect; the sequence completes.
  - Door reopening mid-sequence: restarts from phase 0.
  - hold_mode is sampled only at the final tick.
  - Door already open when RST deasserts: sync regs restart at 0, so a rise is detected and a sequence starts at edge 3 after release.
  - Channels are fully independent. No arbitration and no shared counters.

Test Plan:
- Bench config for scenarios 1-4 and 6: N_CH=2, DIV=4, PHASES=4.
- 1. One-shot: hold_mode=0; door_open[0] high for 1 cycle → light[0] = 1 at edge 3. Then high 4 / low 4 / high 4 / low 4 cycles, then 0. done[0] pulses 16 cycles after light rise; busy[0] high for exactly 16 cycles; channel 1 untouched.
- 2. Retrigger: second door_open[0] pulse while light[0] is in phase 2 → light[0] forced to 1 three edges later; the full 16-cycle sequence restarts from the new rise; only one done pulse, at the end.
- 3. Hold mode: hold_mode=1, door_open[0] held 40 cycles → blinking continues with period 8 and no done while open. After release the current sequence finishes at the next phase-3 tick, then light = 0 and done pulses once.
- 4. Independence: rises on ch0 and ch1 staggered by 3 cycles → identical waveforms offset by 3; any_busy is high from the first light rise to the last busy fall.
- 5. Reset mid-blink (N_CH=1, DIV=2, PHASES=2): RST pulsed between edges during phase 1 → light, busy, done drop immediately. With door_open held across RST release, light rises at edge 3 after release.
- 6. Collision: time a new rise to coincide with the final tick (pcnt=3, div=3) → light = 1, pcnt = 0, no done pulse, busy stays high.
